seg_display_arbiter: RTL and testbench
======================================

// Module: seg_display_arbiter
// PURPOSE
//  Shares the 8-digit seven-segment display between N_REQ requesters (score, timer, status, debug).
//  Each requester offers a 32-bit word of eight 4-bit digit codes. The block grants one owner at a time.
//  Rotation is round-robin with a minimum hold time, a blanking gap between owners, and urgent preemption.
//  disp_number drives the number input of the display multiplexer.
// PARAMETERS
//  N_REQ         4             number of requesters (2..8)
//  HOLD_CYCLES   50_000_000    min clk cycles an owner keeps the display (1 s @ 50 MHz)
//  GAP_CYCLES    2_500_000     clk cycles of blank shown between owners (0 = no gap)
//  IDLE_VALUE    32'h0000_0000 disp_number when nobody owns the display
//  BLANK_VALUE   32'hFFFF_FFFF disp_number during GAP
// PORTS
//  clk          in   1           clock clk
//  rst          in   1           reset rst, synchronous, active-high
//  req          in   N_REQ       req[i]=1: requester i wants the display; level, held while wanted
//  urgent       in   N_REQ       urgent[i] is qualified by req[i]; requests preemption
//  req_data     in   32*N_REQ    word for requester i at [32*i +: 32]
//  grant        out  N_REQ       one-hot owner, or all zero
//  owner_id     out  clog2(N_REQ) index of current/last owner
//  disp_number  out  32          word to display mux
//  disp_valid   out  1           1 when grant!=0
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, grant=0, owner_id=0, disp_number=IDLE_VALUE,
//    disp_valid=0, rr_ptr=0, hold_cnt=0, gap_cnt=0. rst mid-operation aborts to these values next edge.
//  - Arbitration pick:
//    - Lowest-index active urgent (req&urgent) wins.
//    - Otherwise round-robin search over req, starting at rr_ptr.
//    - On each grant, rr_ptr := winner+1 mod N_REQ.
//  - IDLE:
//    - If any req, grant winner next edge: grant, owner_id and disp_valid are set, and disp_number=req_data[winner].
//    - Latency from req rise to grant is 1 cycle. No gap is inserted after IDLE.
//  - HOLD:
//    - disp_number tracks req_data[owner] registered (1-cycle lag).
//    - hold_cnt counts 0..HOLD_CYCLES-1.
//  - HOLD exits (priority order):
//    a) req[owner]=0: drop grant. Go to GAP if other req pending, else IDLE (disp_number=IDLE_VALUE).
//    b) (req&urgent) from a non-owner: preempt immediately, ignoring hold_cnt, and go to GAP.
//       urgent from the owner itself has no effect.
//    c) hold expired and another req pending: go to GAP.
//    d) hold expired and no other req pending: owner keeps the display and hold_cnt restarts at 0.
//  - GAP:
//    - grant=0, disp_valid=0, disp_number=BLANK_VALUE for GAP_CYCLES.
//    - Winner is picked on the last GAP cycle using req/urgent of that cycle; grant on the next edge.
//    - If no req on that cycle, go to IDLE.
//    - GAP_CYCLES=0 goes directly from HOLD to the next owner on the same edge.
//  - Requests dropped during GAP are not granted. A former owner may win again if it is the only requester.
//  - Counter widths: $clog2(HOLD_CYCLES+1) and $clog2(GAP_CYCLES+1); no wrap beyond terminal count.
//  - Invariant: $onehot0(grant); grant[i] implies owner_id==i.
// STRUCTURE
//  - disp_pkg: DIGITS=8, NUM_W=32, BLANK_VALUE, IDLE_VALUE defaults, and state encoding IDLE/HOLD/GAP (2 bits).
//  - Sub-module rr_arbiter:
//    - Combinational rotating-priority picker with urgent override.
//    - Inputs: req, urgent, rr_ptr. Outputs: winner index and any_valid.
//  - Top holds the FSM, hold/gap counters, rr_ptr and the output registers.
// TESTING  (N_REQ=4, HOLD_CYCLES=8, GAP_CYCLES=2)
//  1. rst held 3 cycles, req=0 -> grant=0, disp_valid=0, disp_number=0 throughout; idle after release.
//  2. req=4'b0100, data2=32'h0000_1234 at cycle t -> t+1: grant=0100, owner_id=2, disp_number=32'h1234;
//     held indefinitely, hold restarts every 8 cycles.
//  3. req=4'b0011 -> req0 owns 8 cycles, GAP 2 cycles (disp_number=FFFF_FFFF, grant=0), then req1 owns;
//     then req0 again (round-robin).
//  4. req1 owns at hold_cnt=3; assert req3+urgent3 -> next edge GAP, 2 cycles later grant=1000.
//     urgent1 from the owner causes no change.
//  5. Owner req0 deasserts at hold_cnt=2 with req=0 elsewhere -> next edge IDLE, disp_number=0.
//     With req2 pending -> GAP then grant=0100.
//  6. rst asserted during GAP and during HOLD -> next edge all outputs at reset values;
//     rr_ptr=0, so the first grant after release goes to the lowest pending index.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and state encoding for the seven-segment display arbiter.
package disp_pkg;

    localparam int DIGITS = 8;
    localparam int NUM_W  = 4 * DIGITS;

    localparam logic [NUM_W-1:0] BLANK_VALUE_DEF = {NUM_W{1'b1}};
    localparam logic [NUM_W-1:0] IDLE_VALUE_DEF  = {NUM_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: lowest-index urgent request wins,
// otherwise the first request found searching upward from rr_ptr.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] urgent,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  winner,
    output logic             any_valid
);

    logic [N_REQ-1:0] hot;
    int               idx;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        winner    = '0;
        idx       = 0;
        hot       = req & urgent;
        any_valid = |req;
        // Loops run from lowest to highest priority; the last hit is kept.
        if (|hot) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (hot[i]) winner = ID_W'(i);
            end
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (req[idx]) winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 8-digit display between requesters: round-robin with minimum
// hold time, blank gap between owners and urgent preemption.
module seg_display_arbiter
    import disp_pkg::*;
#(
    parameter int               N_REQ       = 4,
    parameter int               HOLD_CYCLES = 50_000_000,
    parameter int               GAP_CYCLES  = 2_500_000,
    parameter logic [NUM_W-1:0] IDLE_VALUE  = IDLE_VALUE_DEF,
    parameter logic [NUM_W-1:0] BLANK_VALUE = BLANK_VALUE_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           urgent,
    input  logic [NUM_W*N_REQ-1:0]     req_data,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   owner_id,
    output logic [NUM_W-1:0]           disp_number,
    output logic                       disp_valid
);

    localparam int ID_W   = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [N_REQ-1:0]  grant_nxt;
    logic [ID_W-1:0]   owner_nxt;
    logic [NUM_W-1:0]  number_nxt;
    logic              valid_nxt;

    logic [N_REQ-1:0]  owner_mask, arb_req;
    logic [ID_W-1:0]   winner;
    logic              arb_any, preempt, hold_done, gap_done;
    logic              take_grant, go_gap, go_idle;

    // While holding, the owner is hidden from the picker so "another request"
    // and "urgent from a non-owner" both fall out of the masked vector.
    always_comb begin
        owner_mask = '0;
        if (state == ST_HOLD) owner_mask[owner_id] = 1'b1;
    end

    assign arb_req   = req & ~owner_mask;
    assign preempt   = |(arb_req & urgent);
    assign hold_done = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
    assign gap_done  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_arbiter (
        .req       (arb_req),
        .urgent    (urgent),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (arb_any)
    );

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        owner_nxt  = owner_id;
        number_nxt = disp_number;
        valid_nxt  = disp_valid;
        rr_nxt     = rr_ptr;
        hold_nxt   = hold_cnt;
        gap_nxt    = gap_cnt;
        take_grant = 1'b0;
        go_gap     = 1'b0;
        go_idle    = 1'b0;

        case (state)
            ST_IDLE: take_grant = arb_any;
            ST_HOLD: begin
                number_nxt = req_data[int'(owner_id)*NUM_W +: NUM_W];
                if (!req[owner_id]) begin
                    go_gap  = arb_any;
                    go_idle = !arb_any;
                end else if (preempt) begin
                    go_gap = 1'b1;
                end else if (hold_done) begin
                    go_gap   = arb_any;
                    hold_nxt = '0;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    take_grant = arb_any;
                    go_idle    = !arb_any;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: go_idle = 1'b1;
        endcase

        // With no gap configured the next owner is granted on the same edge.
        if (go_gap && GAP_CYCLES == 0) begin
            go_gap     = 1'b0;
            take_grant = 1'b1;
        end

        if (take_grant) begin
            state_nxt         = ST_HOLD;
            grant_nxt         = '0;
            grant_nxt[winner] = 1'b1;
            owner_nxt         = winner;
            valid_nxt         = 1'b1;
            number_nxt        = req_data[int'(winner)*NUM_W +: NUM_W];
            rr_nxt            = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
            hold_nxt          = '0;
        end else if (go_gap) begin
            state_nxt  = ST_GAP;
            grant_nxt  = '0;
            valid_nxt  = 1'b0;
            number_nxt = BLANK_VALUE;
            gap_nxt    = '0;
        end else if (go_idle) begin
            state_nxt  = ST_IDLE;
            grant_nxt  = '0;
            valid_nxt  = 1'b0;
            number_nxt = IDLE_VALUE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant       <= '0;
            owner_id    <= '0;
            disp_number <= IDLE_VALUE;
            disp_valid  <= 1'b0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            owner_id    <= owner_nxt;
            disp_number <= number_nxt;
            disp_valid  <= valid_nxt;
            rr_ptr      <= rr_nxt;
            hold_cnt    <= hold_nxt;
            gap_cnt     <= gap_nxt;
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter (N_REQ=4, HOLD_CYCLES=8, GAP_CYCLES=2).
module tb_seg_display_arbiter;

    localparam logic [31:0] D0    = 32'h1111_0000;
    localparam logic [31:0] D1    = 32'h2222_0001;
    localparam logic [31:0] D2A   = 32'h0000_1234;
    localparam logic [31:0] D2B   = 32'h0000_5678;
    localparam logic [31:0] D3    = 32'h3333_0003;
    localparam logic [31:0] BLANK = 32'hFFFF_FFFF;
    localparam logic [31:0] IDLE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  urgent;
    logic [31:0] data [4];
    logic [127:0] req_data;
    logic [3:0]  grant;
    logic [1:0]  owner_id;
    logic [31:0] disp_number;
    logic        disp_valid;

    int errors = 0;
    int checks = 0;

    assign req_data = {data[3], data[2], data[1], data[0]};

    always #5 clk = ~clk;

    seg_display_arbiter #(
        .N_REQ       (4),
        .HOLD_CYCLES (8),
        .GAP_CYCLES  (2),
        .IDLE_VALUE  (32'h0000_0000),
        .BLANK_VALUE (32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .urgent      (urgent),
        .req_data    (req_data),
        .grant       (grant),
        .owner_id    (owner_id),
        .disp_number (disp_number),
        .disp_valid  (disp_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [31:0] n,
                              input logic v);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".disp_number"}, disp_number, n);
        check({tag, ".disp_valid"}, 32'(disp_valid), 32'(v));
    endtask

    task automatic expect_owner(input string tag, input logic [1:0] o);
        check({tag, ".owner_id"}, 32'(owner_id), 32'(o));
    endtask

    initial begin
        rst     = 1'b1;
        req     = 4'b0000;
        urgent  = 4'b0000;
        data[0] = D0;
        data[1] = D1;
        data[2] = D2A;
        data[3] = D3;

        // 1: reset held three cycles, then idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_out("t1_rst", 4'b0000, IDLE, 1'b0);
        end
        expect_owner("t1_rst", 2'd0);
        rst = 1'b0;
        @(negedge clk);
        expect_out("t1_idle_a", 4'b0000, IDLE, 1'b0);
        @(negedge clk);
        expect_out("t1_idle_b", 4'b0000, IDLE, 1'b0);

        // 2: single requester, 1-cycle latency, data tracked with 1-cycle lag, held forever
        req = 4'b0100;
        @(negedge clk);
        expect_out("t2_grant", 4'b0100, D2A, 1'b1);
        expect_owner("t2_grant", 2'd2);
        data[2] = D2B;
        @(negedge clk);
        check("t2_track", disp_number, D2B);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t2_hold", 32'(grant), 32'(4'b0100));
        end
        req = 4'b0000;
        @(negedge clk);
        expect_out("t2_drop_idle", 4'b0000, IDLE, 1'b0);
        expect_owner("t2_drop_idle", 2'd2);

        // 3: round-robin between req0 and req1 with hold and gap (rr_ptr=3 here)
        req = 4'b0011;
        @(negedge clk);
        expect_out("t3_own0_first", 4'b0001, D0, 1'b1);
        expect_owner("t3_own0_first", 2'd0);
        repeat (7) @(negedge clk);
        expect_out("t3_own0_last", 4'b0001, D0, 1'b1);
        @(negedge clk);
        expect_out("t3_gap_a", 4'b0000, BLANK, 1'b0);
        @(negedge clk);
        expect_out("t3_gap_b", 4'b0000, BLANK, 1'b0);
        @(negedge clk);
        expect_out("t3_own1", 4'b0010, D1, 1'b1);
        expect_owner("t3_own1", 2'd1);
        repeat (7) @(negedge clk);
        expect_out("t3_own1_last", 4'b0010, D1, 1'b1);
        repeat (3) @(negedge clk);
        expect_out("t3_own0_again", 4'b0001, D0, 1'b1);

        // 4: req1 owns again; owner urgent ignored; urgent3 preempts at hold_cnt=3
        repeat (10) @(negedge clk);
        expect_out("t4_own1", 4'b0010, D1, 1'b1);
        @(negedge clk);
        urgent = 4'b0010;
        @(negedge clk);
        expect_out("t4_owner_urgent_a", 4'b0010, D1, 1'b1);
        @(negedge clk);
        expect_out("t4_owner_urgent_b", 4'b0010, D1, 1'b1);
        req    = 4'b1011;
        urgent = 4'b1000;
        @(negedge clk);
        expect_out("t4_preempt_gap_a", 4'b0000, BLANK, 1'b0);
        @(negedge clk);
        expect_out("t4_preempt_gap_b", 4'b0000, BLANK, 1'b0);
        @(negedge clk);
        expect_out("t4_urgent_own3", 4'b1000, D3, 1'b1);
        expect_owner("t4_urgent_own3", 2'd3);

        // 5: owner drop -> GAP when others pend, -> IDLE when none
        req    = 4'b0001;
        urgent = 4'b0000;
        @(negedge clk);
        expect_out("t5_drop_gap", 4'b0000, BLANK, 1'b0);
        repeat (2) @(negedge clk);
        expect_out("t5_own0", 4'b0001, D0, 1'b1);
        repeat (2) @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        expect_out("t5_drop_idle", 4'b0000, IDLE, 1'b0);
        expect_owner("t5_drop_idle", 2'd0);
        req = 4'b0001;
        @(negedge clk);
        expect_out("t5_own0_b", 4'b0001, D0, 1'b1);
        repeat (2) @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        expect_out("t5_gap_a", 4'b0000, BLANK, 1'b0);
        @(negedge clk);
        expect_out("t5_gap_b", 4'b0000, BLANK, 1'b0);
        @(negedge clk);
        expect_out("t5_own2", 4'b0100, D2B, 1'b1);
        expect_owner("t5_own2", 2'd2);

        // 6: reset during GAP and during HOLD; rr_ptr restarts at 0
        req = 4'b0001;
        @(negedge clk);
        expect_out("t6_in_gap", 4'b0000, BLANK, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        expect_out("t6_rst_gap", 4'b0000, IDLE, 1'b0);
        expect_owner("t6_rst_gap", 2'd0);
        rst = 1'b0;
        req = 4'b1010;
        @(negedge clk);
        expect_out("t6_first_after_gap_rst", 4'b0010, D1, 1'b1);
        expect_owner("t6_first_after_gap_rst", 2'd1);
        rst = 1'b1;
        @(negedge clk);
        expect_out("t6_rst_hold", 4'b0000, IDLE, 1'b0);
        expect_owner("t6_rst_hold", 2'd0);
        rst = 1'b0;
        req = 4'b1001;
        @(negedge clk);
        expect_out("t6_first_after_hold_rst", 4'b0001, D0, 1'b1);
        expect_owner("t6_first_after_hold_rst", 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
